// File: rtl/mux4x1_scan_ctrl.sv
// Timed channel scanner for a 4:1 mux stage: steps the selects, samples mux_y
// after a settle delay per channel, and hands the 4-bit word downstream.
module mux4x1_scan_ctrl #(
    parameter int unsigned SETTLE     = 2,
    parameter int unsigned CONTINUOUS = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mux_y,
    output logic       sel0,
    output logic       sel1,
    output logic       busy,
    output logic [3:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       start_drop
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned CH_W  = 2;
    localparam int unsigned DW    = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            r_state;
    logic [CH_W-1:0]   r_ch;
    logic [CNT_W-1:0]  r_cnt;
    logic [CH_W-1:0]   r_sel;
    logic [DW-1:0]     r_shadow;
    logic [DW-1:0]     r_data;
    logic              r_valid;
    logic              r_busy;
    logic              r_drop;

    state_t            w_state_nx;
    logic [CH_W-1:0]   w_ch_nx;
    logic [CNT_W-1:0]  w_cnt_nx;
    logic [CH_W-1:0]   w_sel_nx;
    logic [DW-1:0]     w_shadow_nx;
    logic [DW-1:0]     w_data_nx;
    logic              w_valid_nx;
    logic              w_drop_nx;
    logic              w_capture;

    assign w_capture = (r_cnt == CNT_W'(SETTLE - 1));

    // Next-state and registered-output logic
    always_comb begin
        w_state_nx  = r_state;
        w_ch_nx     = r_ch;
        w_cnt_nx    = r_cnt;
        w_sel_nx    = r_sel;
        w_shadow_nx = r_shadow;
        w_data_nx   = r_data;
        w_valid_nx  = r_valid;
        w_drop_nx   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = S_SETTLE;
                    w_ch_nx    = '0;
                    w_cnt_nx   = '0;
                    w_sel_nx   = '0;
                end
            end
            S_SETTLE: begin
                w_drop_nx = start;
                if (w_capture) begin
                    w_shadow_nx[r_ch] = mux_y;
                    w_cnt_nx          = '0;
                    if (r_ch != CH_W'(3)) begin
                        w_ch_nx  = CH_W'(r_ch + CH_W'(1));
                        w_sel_nx = CH_W'(r_ch + CH_W'(1));
                    end else begin
                        // Final capture: the ch3 bit joins the word on this edge
                        w_state_nx = S_DONE;
                        w_sel_nx   = '0;
                        w_data_nx  = w_shadow_nx;
                        w_valid_nx = 1'b1;
                    end
                end else begin
                    w_cnt_nx = CNT_W'(r_cnt + CNT_W'(1));
                end
            end
            S_DONE: begin
                w_drop_nx = start;
                if (data_ready) begin
                    w_valid_nx = 1'b0;
                    w_ch_nx    = '0;
                    w_cnt_nx   = '0;
                    w_sel_nx   = '0;
                    w_state_nx = (CONTINUOUS != 0) ? S_SETTLE : S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_valid_nx = 1'b0;
                w_sel_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ch     <= '0;
            r_cnt    <= '0;
            r_sel    <= '0;
            r_shadow <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_ch     <= w_ch_nx;
            r_cnt    <= w_cnt_nx;
            r_sel    <= w_sel_nx;
            r_shadow <= w_shadow_nx;
            r_data   <= w_data_nx;
            r_valid  <= w_valid_nx;
            r_busy   <= (w_state_nx != S_IDLE);
            r_drop   <= w_drop_nx;
        end
    end

    assign sel0       = r_sel[1];
    assign sel1       = r_sel[0];
    assign busy       = r_busy;
    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign start_drop = r_drop;

endmodule
